// File: rtl/spi_master_pkg.sv
// spi_master_pkg: types and constants shared by the SPI master blocks.
//   spi_tx_state_e : transmit shifter state (IDLE, TRANSMIT)
//   SPI_WORD_BITS  : width of one TX FIFO word
//   SPI_QUAD_STEP  : bits shifted per SCK edge in quad mode
package spi_master_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } spi_tx_state_e;

  localparam int SPI_WORD_BITS = 32;
  localparam int SPI_QUAD_STEP = 4;

endpackage

// File: rtl/spi_master_tx.sv
// spi_master_tx: transmit shifter of the APB SPI master.
// Pops 32-bit words from the TX FIFO and shifts them MSB-first onto sdo,
// one shift per tx_edge strobe, 1 bit (standard) or 4 bits (quad) per edge.
//
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   en                 start pulse (ignored unless IDLE)
//   tx_edge            SCK shift-edge strobe from the clock generator
//   quad_mode, bit_len transfer mode and length, latched at start
//   data_in, data_in_valid, data_in_ready   TX FIFO word / not-empty / pop
//   sdo                serial data out (standard mode drives sdo[0] only)
//   clk_en_o           SCK run request; low while no word is loaded
//   tx_done            one-cycle completion pulse
//   busy               transfer in progress
//
// Configuration macro: SPI_MASTER_TX_QUAD_EN enables quad mode. Without it
// quad_mode is ignored, every edge shifts one bit and sdo[3:1] stays 0.
module spi_master_tx
  import spi_master_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        en,
  input  logic        tx_edge,
  input  logic        quad_mode,
  input  logic [15:0] bit_len,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [3:0]  sdo,
  output logic        clk_en_o,
  output logic        tx_done,
  output logic        busy
);

  spi_tx_state_e state_q;
  logic [31:0]   shift_q;
  logic [15:0]   bit_cnt_q;
  logic [15:0]   len_q;
  logic [5:0]    word_cnt_q;
  logic          word_empty_q;
  logic          quad_q;
  logic          tx_done_q;

  logic [2:0]    step;
  logic          last_edge;
  logic          word_end;

`ifndef SPI_MASTER_TX_QUAD_EN
  logic unused_quad_mode;
  assign unused_quad_mode = quad_mode;
`endif

  assign step = quad_q ? 3'(SPI_QUAD_STEP) : 3'd1;

  // 17-bit compare so bit_cnt + step cannot wrap near bit_len = 16'hFFFF.
  // A quad length that is not a multiple of 4 finishes on the edge that
  // crosses it, sending the word's tail bits.
  assign last_edge = ({1'b0, bit_cnt_q} + 17'(step)) >= {1'b0, len_q};
  assign word_end  = (7'(word_cnt_q) + 7'(step)) == 7'(SPI_WORD_BITS);

  assign busy          = (state_q == TRANSMIT);
  assign data_in_ready = busy & word_empty_q & data_in_valid & (len_q != 16'd0);
  assign clk_en_o      = busy & ~word_empty_q;
  assign tx_done       = tx_done_q;

`ifdef SPI_MASTER_TX_QUAD_EN
  assign sdo = !busy  ? 4'b0000 :
               quad_q ? shift_q[31:28] : {3'b000, shift_q[31]};
`else
  assign sdo = busy ? {3'b000, shift_q[31]} : 4'b0000;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      word_empty_q <= 1'b1;
      quad_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // en has priority; a tx_edge in the same cycle is simply dropped
          if (en) begin
            len_q        <= bit_len;
`ifdef SPI_MASTER_TX_QUAD_EN
            quad_q       <= quad_mode;
`else
            quad_q       <= 1'b0;
`endif
            bit_cnt_q    <= '0;
            word_empty_q <= 1'b1;
            state_q      <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          if (len_q == 16'd0) begin
            tx_done_q <= 1'b1;
            state_q   <= IDLE;
          end else if (data_in_ready) begin
            shift_q      <= data_in;
            word_cnt_q   <= '0;
            word_empty_q <= 1'b0;
          end else if (!word_empty_q && tx_edge) begin
            shift_q    <= shift_q << step;
            bit_cnt_q  <= bit_cnt_q + 16'(step);
            word_cnt_q <= word_cnt_q + 6'(step);
            if (last_edge) begin
              // unused tail of the current word is discarded
              tx_done_q    <= 1'b1;
              state_q      <= IDLE;
              word_empty_q <= 1'b1;
            end else if (word_end) begin
              word_empty_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
